// File: rtl/hist_pkg.sv
// Shared types and default sizing for the histogram readout path.
package hist_pkg;
  typedef enum logic [2:0] {IDLE, SNAP, HDR, SEND, FIN} state_t;

  localparam int         NBINS_DEF     = 10;
  localparam int         WIDTH_DEF     = 32;
  localparam int         BYTES_PER_BIN = WIDTH_DEF / 8;
  localparam int         FRAME_BYTES   = NBINS_DEF * BYTES_PER_BIN;
  localparam logic [7:0] HEADER_DEF    = 8'hA5;
endpackage

// File: rtl/hist_readout_if.sv
// Byte stream toward the host-link TX FIFO; a byte moves when valid and ready are both high.
interface hist_readout_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/hist_byte_mux.sv
// Picks one byte of the snapshot by flat index: bins ascending, bytes little-endian within a bin.
module hist_byte_mux #(
  parameter int NBINS = 10,
  parameter int WIDTH = 32,
  parameter int IW    = 6
) (
  input  logic [WIDTH-1:0] snap [NBINS],
  input  logic [IW-1:0]    idx,
  output logic [7:0]       dout
);
  localparam int BPB = WIDTH / 8;

  always_comb begin
    dout = '0;
    for (int b = 0; b < NBINS; b++)
      for (int k = 0; k < BPB; k++)
        if (idx == IW'(b * BPB + k)) dout = snap[b][8*k +: 8];
  end
endmodule

// File: rtl/hist_readout.sv
// Snapshots the live bin counters on request and streams them as a header plus bin bytes,
// so a slow host link never stalls accumulation.
module hist_readout
  import hist_pkg::*;
#(
  parameter int         NBINS         = NBINS_DEF,
  parameter int         WIDTH         = WIDTH_DEF,
  parameter bit         CLEAR_ON_READ = 1'b1,
  parameter logic [7:0] HEADER        = HEADER_DEF
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic [WIDTH-1:0] histo [NBINS],
  input  logic             rd_req,
  hist_readout_if.master   tx,
  output logic             hist_clear,
  output logic             busy,
  output logic             done
);
  localparam int          NBYTES = NBINS * (WIDTH / 8);
  localparam int          IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  state_t           state, nxt;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] snap [NBINS];
  logic [7:0]       mux_byte;
  logic             accept;

  assign accept = tx.tx_valid & tx.tx_ready;

  hist_byte_mux #(.NBINS(NBINS), .WIDTH(WIDTH), .IW(IW)) u_mux (
    .snap (snap),
    .idx  (idx),
    .dout (mux_byte)
  );

  always_ff @(posedge clkin) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      for (int i = 0; i < NBINS; i++) snap[i] <= '0;
    end else begin
      state <= nxt;
      if (state == SNAP)
        for (int i = 0; i < NBINS; i++) snap[i] <= histo[i];
      // idx only moves on acceptance, which keeps tx_data stable under backpressure
      if (state == HDR && accept)
        idx <= '0;
      else if (state == SEND && accept && idx != LAST)
        idx <= idx + 1'b1;
    end
  end

  always_comb begin
    nxt         = state;
    tx.tx_valid = 1'b0;
    tx.tx_data  = '0;
    hist_clear  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: if (rd_req) nxt = SNAP;
      SNAP: begin
        busy       = 1'b1;
        hist_clear = CLEAR_ON_READ;
        nxt        = HDR;
      end
      HDR: begin
        busy        = 1'b1;
        tx.tx_valid = 1'b1;
        tx.tx_data  = HEADER;
        if (tx.tx_ready) nxt = SEND;
      end
      SEND: begin
        busy        = 1'b1;
        tx.tx_valid = 1'b1;
        tx.tx_data  = mux_byte;
        if (tx.tx_ready && idx == LAST) nxt = FIN;
      end
      FIN: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_hist_readout.sv
// Directed bench: a frame-queue model checks every cycle, plus literal byte/timing pins.
module tb_hist_readout;
  import hist_pkg::*;

  localparam int NB = 10;

  logic        clkin = 1'b0;
  logic        reset = 1'b1;
  logic        rd_req = 1'b0, rd_req1 = 1'b0;
  logic [31:0] histo [NB];
  logic        hist_clear, busy, done;
  logic        hist_clear1, busy1, done1;

  hist_readout_if tx ();
  hist_readout_if tx1 ();

  always #5 clkin = ~clkin;

  hist_readout dut (
    .clkin(clkin), .reset(reset), .histo(histo), .rd_req(rd_req), .tx(tx),
    .hist_clear(hist_clear), .busy(busy), .done(done)
  );

  hist_readout #(.CLEAR_ON_READ(1'b0)) dut1 (
    .clkin(clkin), .reset(reset), .histo(histo), .rd_req(rd_req1), .tx(tx1),
    .hist_clear(hist_clear1), .busy(busy1), .done(done1)
  );

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a request seen while idle schedules a snapshot; the snapshot edge turns the
  // live counters into the whole expected frame; each accepted byte pops it; done follows.
  logic [7:0] q [$];
  bit         m_snap, m_done;

  always @(posedge clkin) begin
    if (reset) begin
      q.delete();
      m_snap = 1'b0;
      m_done = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_snap) begin
      q.push_back(8'hA5);
      for (int b = 0; b < NB; b++)
        for (int k = 0; k < 4; k++) q.push_back(histo[b][8*k +: 8]);
      m_snap = 1'b0;
    end else if (q.size() > 0) begin
      if (tx.tx_ready) begin
        void'(q.pop_front());
        if (q.size() == 0) m_done = 1'b1;
      end
    end else if (rd_req) begin
      m_snap = 1'b1;
    end
  end

  logic [7:0] acc [$];
  logic [7:0] acc1 [$];
  int         n_clr = 0, n_done = 0;
  logic       pv = 1'b0, pr = 1'b0, prst = 1'b1;
  logic [7:0] pd = '0;

  always @(negedge clkin) begin
    chk("valid", tx.tx_valid, q.size() > 0);
    if (q.size() > 0) chk("data", tx.tx_data, q[0]);
    chk("busy", busy, m_snap || q.size() > 0);
    chk("hist_clear", hist_clear, m_snap);
    chk("done", done, m_done);
    chk("hist_clear1", hist_clear1, 1'b0);
    if (pv && !pr && !prst) begin
      chk("stall_valid", tx.tx_valid, 1'b1);
      chk("stall_data", tx.tx_data, pd);
    end
    if (tx.tx_valid && tx.tx_ready) acc.push_back(tx.tx_data);
    if (tx1.tx_valid && tx1.tx_ready) acc1.push_back(tx1.tx_data);
    if (hist_clear) n_clr++;
    if (done) n_done++;
    pv = tx.tx_valid; pr = tx.tx_ready; pd = tx.tx_data; prst = reset;
  end

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic req();
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  // Runs until the model is idle again; bp randomises tx_ready with forced 5-cycle lows.
  task automatic run_frame(input bit bp, input int lim);
    int k = 0;
    for (int i = 0; i < lim; i++) begin
      if (bp) begin
        if (k > 0) begin tx.tx_ready = 1'b0; k--; end
        else if (i == 10 || $urandom_range(0, 7) == 0) begin tx.tx_ready = 1'b0; k = 4; end
        else tx.tx_ready = 1'($urandom_range(0, 1));
      end
      tick();
      if (!m_snap && q.size() == 0 && !m_done) begin
        tx.tx_ready = 1'b1;
        return;
      end
    end
    tx.tx_ready = 1'b1;
    timeout("run_frame");
  endtask

  task automatic wait_acc(input int n, input int lim);
    for (int i = 0; i < lim; i++) begin
      if (acc.size() >= n) return;
      tick();
    end
    timeout("wait_acc");
  endtask

  logic [7:0] ref2 [$];

  initial begin
    tx.tx_ready  = 1'b1;
    tx1.tx_ready = 1'b1;
    for (int i = 0; i < NB; i++) histo[i] = 32'h0000_0100 * i + i;
    repeat (3) tick();
    chk("rst_valid", tx.tx_valid, 1'b0);
    chk("rst_data", tx.tx_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_clear", hist_clear, 1'b0);
    reset = 1'b0;
    tick();

    // basic frame
    acc.delete(); n_clr = 0; n_done = 0;
    req();
    run_frame(1'b0, 200);
    tick();
    chk("frame_len", acc.size(), 41);
    if (acc.size() == 41) begin
      chk("hdr", acc[0], 8'hA5);
      for (int i = 1; i <= 4; i++) chk("bin0", acc[i], 8'h00);
      chk("bin1_b0", acc[5], 8'h01);
      chk("bin1_b1", acc[6], 8'h01);
      chk("bin1_b2", acc[7], 8'h00);
      chk("bin1_b3", acc[8], 8'h00);
      chk("bin9_b0", acc[37], 8'h09);
      chk("bin9_b1", acc[38], 8'h09);
      chk("bin9_b2", acc[39], 8'h00);
      chk("bin9_b3", acc[40], 8'h00);
    end
    chk("clear_cycles", n_clr, 1);
    chk("done_count", n_done, 1);
    ref2 = acc;

    // backpressure: same bytes, stability checked every stalled cycle
    acc.delete();
    req();
    run_frame(1'b1, 2000);
    tick();
    chk("bp_len", acc.size(), 41);
    if (acc.size() == 41 && ref2.size() == 41)
      for (int i = 0; i < 41; i++) chk("bp_byte", acc[i], ref2[i]);

    // snapshot isolation
    acc.delete();
    req();
    tick();
    for (int i = 0; i < NB; i++) histo[i] = 32'hFFFF_FFFF;
    run_frame(1'b0, 200);
    tick();
    chk("iso_len", acc.size(), 41);
    if (acc.size() == 41 && ref2.size() == 41)
      for (int i = 0; i < 41; i++) chk("iso_byte", acc[i], ref2[i]);
    for (int i = 0; i < NB; i++) histo[i] = 32'h0000_0100 * i + i;

    // requests while busy are dropped
    acc.delete(); n_done = 0;
    req();
    wait_acc(3, 200);
    req();
    wait_acc(40, 200);
    req();
    run_frame(1'b0, 200);
    tick();
    chk("busy_req_len", acc.size(), 41);
    chk("busy_req_done", n_done, 1);
    req();
    chk("lat_snap_valid", tx.tx_valid, 1'b0);
    tick();
    chk("lat_hdr_valid", tx.tx_valid, 1'b1);
    chk("lat_hdr_data", tx.tx_data, 8'hA5);
    run_frame(1'b0, 200);
    tick();

    // reset mid-frame
    acc.delete(); n_done = 0;
    req();
    wait_acc(10, 200);
    reset = 1'b1;
    tick();
    chk("mid_rst_valid", tx.tx_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    reset = 1'b0;
    tick();
    chk("mid_rst_no_done", n_done, 0);
    acc.delete();
    req();
    run_frame(1'b0, 200);
    tick();
    chk("fresh_len", acc.size(), 41);
    chk("fresh_done", n_done, 1);
    if (acc.size() == 41 && ref2.size() == 41)
      for (int i = 0; i < 41; i++) chk("fresh_byte", acc[i], ref2[i]);

    // no clear variant
    histo[0] = 32'hDEAD_BEEF;
    acc1.delete();
    rd_req1 = 1'b1;
    tick();
    rd_req1 = 1'b0;
    for (int i = 0; i < 200 && acc1.size() < 41; i++) tick();
    repeat (2) tick();
    chk("nc_len", acc1.size(), 41);
    if (acc1.size() == 41) begin
      chk("nc_hdr", acc1[0], 8'hA5);
      chk("nc_b0", acc1[1], 8'hEF);
      chk("nc_b1", acc1[2], 8'hBE);
      chk("nc_b2", acc1[3], 8'hAD);
      chk("nc_b3", acc1[4], 8'hDE);
    end
    chk("nc_idle", busy1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hist_readout.md
Name: hist_readout

Overview:
- Downstream consumer of the 10-bin hit histogrammer.
- On a read request, it snapshots all bin counters in one cycle and optionally pulses the histogrammer's clear input.
- It then streams the snapshot as bytes over a valid/ready byte interface to the host-link TX FIFO.
- It decouples the free-running counters from a slow host link, so readout never stalls accumulation.

Parameters:
- NBINS, 10, number of histogram bins
- WIDTH, 32, bits per bin counter; must be a multiple of 8
- CLEAR_ON_READ, 1, when 1 the snapshot cycle also pulses hist_clear
- HEADER, 8'hA5, sync byte sent before bin data

Ports:
- clkin  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- histo  in  NBINS x WIDTH  live bin counters from the histogrammer (unpacked array, bin 0 first)
- rd_req  in  1  single-cycle read request
- tx_data  out  8  byte to the TX FIFO
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  FIFO accepts the byte on a cycle where tx_valid and tx_ready are both high
- hist_clear  out  1  one-cycle clear pulse, wired to the histogrammer reset input
- busy  out  1  high from request acceptance until the last byte is accepted
- done  out  1  one-cycle pulse after the last byte is accepted

Behaviour:
- Reset values: tx_data=0, tx_valid=0, hist_clear=0, busy=0, done=0, byte counter=0, snapshot=0, state=IDLE. Reset overrides everything, including mid-transfer. A partially sent frame is abandoned and no done pulse is issued.
- States: IDLE, SNAP, HDR, SEND, FIN.
- IDLE: busy=0. When rd_req=1, go to SNAP on the next edge.
- SNAP (one cycle):
  - snap[i] <= histo[i] for all bins, captured at the same edge.
  - hist_clear=1 during this cycle iff CLEAR_ON_READ.
  - busy=1.
  - Next state is HDR.
- Clear timing: the histogrammer registers its reset once, so counts arriving on the two cycles after the snapshot edge are discarded. This loss is accepted and documented for the host.
- HDR:
  - tx_valid=1, tx_data=HEADER.
  - Hold both until accepted, then go to SEND with byte index=0.
- SEND:
  - tx_valid=1, tx_data = byte (idx mod (WIDTH/8)) of snap[idx / (WIDTH/8)].
  - Bytes within a bin are little-endian; bins go in ascending order.
  - The index advances only on acceptance.
  - tx_data and tx_valid must stay stable while tx_ready=0.
  - After byte NBINS*WIDTH/8-1 (default 39) is accepted, go to FIN.
- FIN (one cycle): done=1, tx_valid=0, busy=0. Next state is IDLE.
- Frame length: 1 + NBINS*WIDTH/8 bytes, i.e. 41 at default parameters.
- rd_req while not IDLE: ignored, with no queuing. A request in the FIN cycle is also ignored.
- The snapshot holds the values from the SNAP edge and is unaffected by later histo changes.
- Back-to-back throughput: with tx_ready held high, one byte per cycle. Request-to-first-byte latency is 2 cycles (request edge → SNAP → HDR valid).
- Byte counter width: clog2(NBINS*WIDTH/8). It does not wrap; it is cleared on entry to SEND.

Decomposition:
- Package hist_pkg holds:
  - the state enum typedef (IDLE, SNAP, HDR, SEND, FIN);
  - localparam BYTES_PER_BIN = WIDTH/8;
  - FRAME_BYTES = NBINS*BYTES_PER_BIN;
  - the default HEADER value.
- One natural sub-module, hist_byte_mux: a combinational selector from the snapshot array and byte index to an 8-bit value.
- The FSM, snapshot register and counter stay in hist_readout.

Test Plan:
1. Reset mid-frame: start a read, assert reset at byte 10 → next cycle tx_valid=0, busy=0, no done. A following rd_req yields a fresh full frame.
2. Basic frame:
   - Stimulus: histo[i]=32'h0000_0100*i+i, tx_ready=1, rd_req pulse.
   - Timing: hist_clear high exactly one cycle (the SNAP cycle); 41 consecutive valid bytes; done one cycle after the last byte.
   - Byte order: A5; then bin 0 as 00 00 00 00; bin 1 as 01 01 00 00; bin 9 as 09 09 00 00.
3. Backpressure: toggle tx_ready randomly (including 5-cycle low stretches) → the same 41-byte sequence is produced; tx_data never changes while tx_valid=1 and tx_ready=0.
4. Snapshot isolation: change all histo to 32'hFFFF_FFFF one cycle after SNAP → the transmitted values equal the pre-change values.
5. Request while busy: pulse rd_req at bytes 3 and 40 of a frame → exactly one frame and one done. The frame after the next accepted rd_req starts 2 cycles after it.
6. CLEAR_ON_READ=0, with histo[0]=32'hDEAD_BEEF → hist_clear is never asserted; bin 0 bytes are EF BE AD DE.
